uart_fifo_bridge: RTL and testbench

- Buffering stage between the bus-side UART register block and the UART transceiver core.
- TX FIFO absorbs CPU writes and feeds bytes to the core's single-byte transmit interface as the core goes idle.
- RX FIFO drains each received byte from the core's single-byte receive buffer, storing it with its parity-error flag.
- Result: no byte loss at CPU-side latency up to DEPTH frames.

---
 rtl/uart_fifo_bridge_if.sv | 51 +++++
 rtl/uart_fifo_bridge.sv | 172 +++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_bridge_if.sv
//------------------------------------------------------------------------------
// Module : uart_fifo_bridge_if
// Brief  : Bus-side FIFO access and transceiver-core handshake bundle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_fifo_bridge_if #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
);
    // CPU side
    logic                          tx_wr_en;
    logic [7:0]                    tx_wr_data;
    logic                          tx_full;
    logic [$clog2(TX_DEPTH):0]     tx_count;
    logic                          flush_tx;
    logic                          rx_rd_en;
    logic [7:0]                    rx_rd_data;
    logic                          rx_rd_perr;
    logic                          rx_empty;
    logic [$clog2(RX_DEPTH):0]     rx_count;
    logic                          flush_rx;
    logic                          rx_overrun;
    logic                          clr_overrun;
    logic                          tx_en;
    // transceiver-core side
    logic                          core_dat_we;
    logic [7:0]                    core_dat_di;
    logic                          core_dat_re;
    logic [7:0]                    core_dat_do;
    logic                          core_tx_buf_empty;
    logic                          core_rx_buf_valid;
    logic                          core_err_parity;

    modport slave (
        input  tx_wr_en, tx_wr_data, flush_tx, rx_rd_en, flush_rx, clr_overrun, tx_en,
               core_dat_do, core_tx_buf_empty, core_rx_buf_valid, core_err_parity,
        output tx_full, tx_count, rx_rd_data, rx_rd_perr, rx_empty, rx_count, rx_overrun,
               core_dat_we, core_dat_di, core_dat_re
    );

    modport master (
        output tx_wr_en, tx_wr_data, flush_tx, rx_rd_en, flush_rx, clr_overrun, tx_en,
               core_dat_do, core_tx_buf_empty, core_rx_buf_valid, core_err_parity,
        input  tx_full, tx_count, rx_rd_data, rx_rd_perr, rx_empty, rx_count, rx_overrun,
               core_dat_we, core_dat_di, core_dat_re
    );
endinterface

`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
//------------------------------------------------------------------------------
// Module : uart_fifo_bridge
// Brief  : TX/RX byte FIFOs between the UART register block and the core.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_fifo_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_fifo_bridge_if.slave    bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_HOLD, T_WAIT} tx_state_t;
    typedef enum logic       {R_IDLE, R_ACK} rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [TX_AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic           tx_empty_w, tx_full_w, tx_push_w, tx_pop_w;
    tx_state_t      tx_state_q;
    logic           core_dat_we_q;
    logic [7:0]     core_dat_di_q;

    assign tx_empty_w = (tx_wptr_q == tx_rptr_q);
    assign tx_full_w  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                        (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
    assign tx_push_w  = bus.tx_wr_en && !tx_full_w;
    assign tx_pop_w   = (tx_state_q == T_IDLE) && !tx_empty_w && bus.tx_en && bus.core_tx_buf_empty;

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        if (bus.flush_tx) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
        end else begin
            if (tx_push_w) tx_wptr_d = tx_wptr_q + 1'b1;
            if (tx_pop_w)  tx_rptr_d = tx_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push_w) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= bus.tx_wr_data;
    end

    // A popped byte is always issued, even if flush clears the pointers alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q    <= T_IDLE;
            core_dat_we_q <= 1'b0;
            core_dat_di_q <= 8'h00;
        end else begin
            case (tx_state_q)
                T_IDLE: begin
                    if (tx_pop_w) begin
                        core_dat_di_q <= tx_mem_q[tx_rptr_q[TX_AW-1:0]];
                        core_dat_we_q <= 1'b1;
                        tx_state_q    <= T_ISSUE;
                    end
                end
                T_ISSUE: begin
                    core_dat_we_q <= 1'b0;
                    tx_state_q    <= T_HOLD;
                end
                T_HOLD:  tx_state_q <= T_WAIT;
                T_WAIT:  if (bus.core_tx_buf_empty) tx_state_q <= T_IDLE;
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    assign bus.tx_full     = tx_full_w;
    assign bus.tx_count    = tx_wptr_q - tx_rptr_q;
    assign bus.core_dat_we = core_dat_we_q;
    assign bus.core_dat_di = core_dat_di_q;

    // ---------------- RX FIFO ----------------
    logic [8:0]     rx_mem_q [RX_DEPTH];
    logic [RX_AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic           rx_empty_w, rx_full_w, rx_take_w, rx_push_w, rx_drop_w, rx_pop_w;
    rx_state_t      rx_state_q;
    logic           core_dat_re_q;
    logic           rx_overrun_q;

    assign rx_empty_w = (rx_wptr_q == rx_rptr_q);
    assign rx_full_w  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                        (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
    assign rx_take_w  = (rx_state_q == R_IDLE) && bus.core_rx_buf_valid;
    assign rx_push_w  = rx_take_w && !rx_full_w && !bus.flush_rx;
    assign rx_drop_w  = rx_take_w && (rx_full_w || bus.flush_rx);
    assign rx_pop_w   = bus.rx_rd_en && !rx_empty_w;

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        if (bus.flush_rx) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
        end else begin
            if (rx_push_w) rx_wptr_d = rx_wptr_q + 1'b1;
            if (rx_pop_w)  rx_rptr_d = rx_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push_w) rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= {bus.core_err_parity, bus.core_dat_do};
    end

    // The ack is issued even for a dropped byte so the core never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= R_IDLE;
            core_dat_re_q <= 1'b0;
        end else begin
            case (rx_state_q)
                R_IDLE: begin
                    if (rx_take_w) begin
                        core_dat_re_q <= 1'b1;
                        rx_state_q    <= R_ACK;
                    end
                end
                R_ACK: begin
                    core_dat_re_q <= 1'b0;
                    rx_state_q    <= R_IDLE;
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)              rx_overrun_q <= 1'b0;
        else if (rx_drop_w)   rx_overrun_q <= 1'b1;
        else if (bus.clr_overrun) rx_overrun_q <= 1'b0;
    end

    assign bus.rx_empty    = rx_empty_w;
    assign bus.rx_count    = rx_wptr_q - rx_rptr_q;
    assign bus.rx_rd_data  = rx_mem_q[rx_rptr_q[RX_AW-1:0]][7:0];
    assign bus.rx_rd_perr  = rx_mem_q[rx_rptr_q[RX_AW-1:0]][8];
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.core_dat_re = core_dat_re_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
//------------------------------------------------------------------------------
// Module : tb_uart_fifo_bridge
// Brief  : Randomized bench for uart_fifo_bridge against a queue-based model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_fifo_bridge;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_fifo_bridge_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) bus ();

    uart_fifo_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [7:0] txq[$];
    logic [8:0] rxq[$];
    bit         ovr_m;
    int         cyc = 0, last_we = -100, last_cap = -100;
    int         tx_issued = 0, n_caps = 0;
    bit         be_prev = 1'b1;
    // core behaviour
    int         tx_busy = 0;
    logic [8:0] rx_src[$];
    bit         rx_hold = 1'b0, rx_acked = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit p_rst, p_wr, p_ftx, p_rd, p_frx, p_clr, p_en, p_be, p_val;
        logic [7:0] p_wd;
        logic [8:0] p_frame, f;
        bit full_b, allowed, cap, rfull, rpop;
        p_rst = rst; p_wr = bus.tx_wr_en; p_wd = bus.tx_wr_data; p_ftx = bus.flush_tx;
        p_rd = bus.rx_rd_en; p_frx = bus.flush_rx; p_clr = bus.clr_overrun; p_en = bus.tx_en;
        p_be = bus.core_tx_buf_empty; p_val = bus.core_rx_buf_valid;
        p_frame = {bus.core_err_parity, bus.core_dat_do};
        @(posedge clk);
        cyc++;
        #1;
        if (p_rst) begin
            txq.delete(); rxq.delete(); ovr_m = 1'b0;
            last_we = -100; last_cap = -100;
            check_value("rst_we", bus.core_dat_we, 1'b0);
            check_value("rst_re", bus.core_dat_re, 1'b0);
            check_value("rst_di", bus.core_dat_di, 8'h00);
        end else begin
            // TX: a byte may leave only when queued, enabled, core idle, and >=4 cycles apart
            full_b  = (txq.size() == TXD);
            allowed = (txq.size() > 0) && p_en && p_be;
            if (bus.core_dat_we) begin
                check_value("tx_allowed", allowed, 1'b1);
                check_value("tx_spacing", (cyc - last_we) >= 4, 1'b1);
                if (txq.size() > 0) begin
                    check_value("tx_di", bus.core_dat_di, txq[0]);
                    void'(txq.pop_front());
                end
                last_we = cyc;
                tx_issued++;
            end else if (allowed && (cyc - last_we) >= 4 && be_prev) begin
                check_value("tx_issue", bus.core_dat_we, 1'b1);
            end
            if (p_wr && !full_b) txq.push_back(p_wd);
            if (p_ftx) txq.delete();
            // RX: capture whenever valid is seen and the previous capture is >=2 cycles old
            cap = p_val && ((cyc - last_cap) >= 2);
            check_value("rx_re", bus.core_dat_re, cap);
            if (cap) begin
                last_cap = cyc;
                n_caps++;
            end
            rfull = (rxq.size() == RXD);
            rpop  = p_rd && (rxq.size() > 0);
            if (p_frx) rxq.delete();
            else begin
                if (rpop) void'(rxq.pop_front());
                if (cap && !rfull) rxq.push_back(p_frame);
            end
            if (cap && (rfull || p_frx)) ovr_m = 1'b1;
            else if (p_clr)              ovr_m = 1'b0;
        end
        be_prev = p_be;
        // core transmitter: busy for a random time after each strobe
        if (bus.core_dat_we) begin
            bus.core_tx_buf_empty = 1'b0;
            tx_busy = $urandom_range(1, 4);
        end else if (tx_busy > 0) begin
            tx_busy--;
            if (tx_busy == 0) bus.core_tx_buf_empty = 1'b1;
        end
        // core receiver: hold valid until acked, clear it after the ack cycle
        if (rx_hold && bus.core_dat_re) rx_acked = 1'b1;
        else if (rx_acked) begin
            rx_hold = 1'b0; rx_acked = 1'b0; bus.core_rx_buf_valid = 1'b0;
        end
        if (!rx_hold && rx_src.size() > 0) begin
            f = rx_src.pop_front();
            bus.core_dat_do = f[7:0]; bus.core_err_parity = f[8];
            bus.core_rx_buf_valid = 1'b1; rx_hold = 1'b1;
        end
        check_value("tx_count", bus.tx_count, txq.size());
        check_value("tx_full", bus.tx_full, txq.size() == TXD);
        check_value("rx_count", bus.rx_count, rxq.size());
        check_value("rx_empty", bus.rx_empty, rxq.size() == 0);
        check_value("rx_overrun", bus.rx_overrun, ovr_m);
        if (rxq.size() > 0) begin
            check_value("rx_rd_data", bus.rx_rd_data, rxq[0][7:0]);
            check_value("rx_rd_perr", bus.rx_rd_perr, rxq[0][8]);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.tx_wr_en = 1'b1; bus.tx_wr_data = b;
        step();
        bus.tx_wr_en = 1'b0;
    endtask

    task automatic drain_tx(input int limit);
        for (int i = 0; i < limit && (txq.size() > 0 || !bus.core_tx_buf_empty); i++) step();
        check_value("tx_drained", txq.size(), 0);
    endtask

    task automatic settle_rx(input int limit);
        for (int i = 0; i < limit && (rx_src.size() > 0 || rx_hold); i++) step();
        check_value("rx_settled", rx_src.size() + int'(rx_hold), 0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.tx_wr_en = 0; bus.tx_wr_data = 0; bus.flush_tx = 0; bus.rx_rd_en = 0;
        bus.flush_rx = 0; bus.clr_overrun = 0; bus.tx_en = 0;
        bus.core_dat_do = 0; bus.core_tx_buf_empty = 1; bus.core_rx_buf_valid = 0;
        bus.core_err_parity = 0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // three bytes with the core idle
        bus.tx_en = 1'b1;
        base = tx_issued;
        write_byte(8'h55); write_byte(8'hA3); write_byte(8'h0F);
        drain_tx(100);
        check_value("tx_three_issued", tx_issued - base, 3);

        // fill past full while disabled, then release
        bus.tx_en = 1'b0;
        for (int i = 0; i < 17; i++) write_byte(8'($urandom));
        step();
        check_value("tx_full_17", bus.tx_full, 1'b1);
        check_value("tx_count_16", bus.tx_count, TXD);
        base = tx_issued;
        bus.tx_en = 1'b1;
        drain_tx(200);
        check_value("tx_sixteen_issued", tx_issued - base, 16);

        // single frame with a parity error
        rx_src.push_back({1'b1, 8'h3C});
        settle_rx(20);
        check_value("rx_one_data", bus.rx_rd_data, 8'h3C);
        check_value("rx_one_perr", bus.rx_rd_perr, 1'b1);
        check_value("rx_one_count", bus.rx_count, 1);
        bus.rx_rd_en = 1'b1; step(); bus.rx_rd_en = 1'b0;
        check_value("rx_one_empty", bus.rx_empty, 1'b1);

        // 17 frames with no reads
        base = n_caps;
        for (int i = 0; i < 17; i++) rx_src.push_back(9'($urandom));
        settle_rx(200);
        step();
        check_value("rx_caps_17", n_caps - base, 17);
        check_value("rx_count_16", bus.rx_count, RXD);
        check_value("rx_ovr_set", bus.rx_overrun, 1'b1);
        bus.clr_overrun = 1'b1; step(); bus.clr_overrun = 1'b0;
        check_value("rx_ovr_clr", bus.rx_overrun, 1'b0);
        bus.rx_rd_en = 1'b1; repeat (RXD) step(); bus.rx_rd_en = 1'b0;

        // read and capture on the same edge at count 5
        for (int i = 0; i < 5; i++) rx_src.push_back(9'($urandom));
        settle_rx(50);
        step();
        rx_src.push_back(9'h1A5);
        step();
        bus.rx_rd_en = 1'b1; step(); bus.rx_rd_en = 1'b0;
        check_value("rx_simul_count", bus.rx_count, 5);
        settle_rx(20);
        // flush with a same-edge capture; set beats a simultaneous clear
        rx_src.push_back(9'h0C3);
        step();
        bus.flush_rx = 1'b1; bus.clr_overrun = 1'b1; step();
        bus.flush_rx = 1'b0; bus.clr_overrun = 1'b0;
        check_value("rx_flush_count", bus.rx_count, 0);
        check_value("rx_flush_ovr", bus.rx_overrun, 1'b1);
        settle_rx(20);
        bus.clr_overrun = 1'b1; step(); bus.clr_overrun = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.tx_wr_en    = ($urandom_range(0, 2) == 0);
            bus.tx_wr_data  = 8'($urandom);
            bus.rx_rd_en    = ($urandom_range(0, 2) == 0);
            bus.clr_overrun = ($urandom_range(0, 29) == 0);
            bus.flush_tx    = ($urandom_range(0, 99) == 0);
            bus.flush_rx    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) bus.tx_en = ~bus.tx_en;
            if ($urandom_range(0, 3) == 0 && rx_src.size() < 4) rx_src.push_back(9'($urandom));
            step();
        end
        bus.tx_wr_en = 0; bus.rx_rd_en = 0; bus.clr_overrun = 0;
        bus.flush_tx = 0; bus.flush_rx = 0; bus.tx_en = 1'b1;
        drain_tx(300);
        settle_rx(50);

        // reset while the TX side waits on the core
        write_byte(8'h99);
        for (int i = 0; i < 20 && last_we != cyc; i++) step();
        check_value("h_we_seen", last_we, cyc);
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        // reset during the RX ack cycle
        rx_src.push_back(9'h042);
        for (int i = 0; i < 20 && !bus.core_dat_re; i++) step();
        check_value("h_re_seen", bus.core_dat_re, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        step();
        base = tx_issued;
        write_byte(8'h77);
        drain_tx(100);
        check_value("h_post_rst_issue", tx_issued - base, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
